// File: rtl/pixel_byte_unpacker.sv
// Byte-to-pixel unpacker: hunts SYNC_BYTE, then emits PIXEL_COUNT bits (1 FILL + up to 8 EMIT cycles per byte),
// stalling on pixel_bit_ready and holding off bytes while emitting; PIXEL_UNPACK_LSB_FIRST_EN selects bit0-first.
module pixel_byte_unpacker #(
    parameter int unsigned PIXEL_COUNT = 784,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             pixel_bit,
    output logic             pixel_bit_valid,
    input  logic             pixel_bit_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       drop_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIXEL_COUNT);
    localparam logic [CNT_W-1:0] PIX_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PIX_EIGHT = CNT_W'(8);

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [CNT_W-1:0] pix_left_q, pix_left_d;
    logic             valid_q, valid_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic             byte_xfer;
    logic             pix_xfer;
    logic [3:0]       fill_bits;
    logic [7:0]       shreg_shifted;

    assign byte_ready = (state_q != EMIT) && !rst;
    assign byte_xfer  = byte_valid && byte_ready;
    assign pix_xfer   = valid_q && pixel_bit_ready;

    // The final byte of a frame may carry fewer live bits than 8.
    assign fill_bits = (pix_left_q >= PIX_EIGHT) ? 4'd8 : pix_left_q[3:0];

`ifdef PIXEL_UNPACK_LSB_FIRST_EN
    assign pixel_bit     = shreg_q[0];
    assign shreg_shifted = {1'b0, shreg_q[7:1]};
`else
    assign pixel_bit     = shreg_q[7];
    assign shreg_shifted = {shreg_q[6:0], 1'b0};
`endif

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bits_left_d   = bits_left_q;
        pix_left_d    = pix_left_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        case (state_q)
            HUNT: begin
                if (byte_xfer) begin
                    if (byte_in == SYNC_BYTE) begin
                        pix_left_d = PIX_TOTAL;
                        state_d    = FILL;
                    end else if (drop_count_q != 8'hFF) begin
                        drop_count_d = drop_count_q + 8'd1;
                    end
                end
            end
            FILL: begin
                if (byte_xfer) begin
                    shreg_d     = byte_in;
                    bits_left_d = fill_bits;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (pix_xfer) begin
                    shreg_d     = shreg_shifted;
                    bits_left_d = bits_left_q - 4'd1;
                    pix_left_d  = pix_left_q - PIX_ONE;
                    // Frame end wins over byte end so padding bits are never shown.
                    if (pix_left_q == PIX_ONE) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + PIX_ONE;
                        state_d       = HUNT;
                    end else if (bits_left_q == 4'd1) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            shreg_q       <= 8'h00;
            bits_left_q   <= 4'd0;
            pix_left_q    <= '0;
            valid_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bits_left_q   <= bits_left_d;
            pix_left_q    <= pix_left_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign pixel_bit_valid = valid_q;
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;
    assign drop_count      = drop_count_q;
    assign busy            = (state_q == FILL) || (state_q == EMIT);

endmodule

// File: tb/tb_pixel_byte_unpacker.sv
// Bench for pixel_byte_unpacker: a 784-pixel instance for full frames and a 10-pixel instance for partial bytes.
module tb_pixel_byte_unpacker;

`ifdef PIXEL_UNPACK_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic clk;
    logic rst;

    logic [7:0]  a_bi, a_dc;
    logic        a_bv, a_br, a_pb, a_pbv, a_pbr, a_fd, a_busy;
    logic [15:0] a_fc;
    logic [7:0]  b_bi, b_dc;
    logic        b_bv, b_br, b_pb, b_pbv, b_pbr, b_fd, b_busy;
    logic [15:0] b_fc;

    pixel_byte_unpacker u_dut (
        .clk(clk), .rst(rst), .byte_in(a_bi), .byte_valid(a_bv), .byte_ready(a_br),
        .pixel_bit(a_pb), .pixel_bit_valid(a_pbv), .pixel_bit_ready(a_pbr),
        .frame_done(a_fd), .frame_count(a_fc), .drop_count(a_dc), .busy(a_busy)
    );

    pixel_byte_unpacker #(.PIXEL_COUNT(10)) u_dut10 (
        .clk(clk), .rst(rst), .byte_in(b_bi), .byte_valid(b_bv), .byte_ready(b_br),
        .pixel_bit(b_pb), .pixel_bit_valid(b_pbv), .pixel_bit_ready(b_pbr),
        .frame_done(b_fd), .frame_count(b_fc), .drop_count(b_dc), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecs = 0;
    int fails = 0;

    logic [7:0] a_tx[$];
    logic       a_rx[$];
    logic [7:0] b_tx[$];
    logic       b_rx[$];
    logic       exp_q[$];
    int a_fd_cnt = 0, a_fd_at = 0, a_fill = 0, a_emit = 0, a_viol = 0;
    int b_fd_cnt = 0;
    bit a_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Driver/monitor for the 784-pixel instance; handshakes are judged at negedge for the next posedge.
    initial begin
        logic       xfer, stall_prev, bit_prev;
        logic [7:0] tmp;
        a_bv = 1'b0; a_bi = 8'h00; a_pbr = 1'b1;
        stall_prev = 1'b0; bit_prev = 1'b0;
        forever begin
            @(negedge clk);
            xfer = a_bv && a_br;
            if (!rst) begin
                if (stall_prev && (!a_pbv || a_pb !== bit_prev)) a_viol++;
                if (a_pbv && a_br) a_viol++;
                if (a_pbv && a_pbr) a_rx.push_back(a_pb);
                if (a_fd) begin
                    a_fd_cnt++;
                    a_fd_at = a_rx.size();
                end
                if (a_busy && !a_pbv) a_fill++;
                if (a_pbv) a_emit++;
                stall_prev = a_pbv && !a_pbr;
                bit_prev   = a_pb;
            end else begin
                stall_prev = 1'b0;
            end
            @(posedge clk);
            #1;
            if (xfer && a_tx.size() > 0) tmp = a_tx.pop_front();
            a_bv  = (a_tx.size() > 0);
            a_bi  = a_bv ? a_tx[0] : 8'h00;
            a_pbr = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic       xfer;
        logic [7:0] tmp;
        b_bv = 1'b0; b_bi = 8'h00; b_pbr = 1'b1;
        forever begin
            @(negedge clk);
            xfer = b_bv && b_br;
            if (!rst) begin
                if (b_pbv && b_pbr) b_rx.push_back(b_pb);
                if (b_fd) b_fd_cnt++;
            end
            @(posedge clk);
            #1;
            if (xfer && b_tx.size() > 0) tmp = b_tx.pop_front();
            b_bv = (b_tx.size() > 0);
            b_bi = b_bv ? b_tx[0] : 8'h00;
        end
    end

    task automatic wait_a(input int target, input int limit);
        int n = 0;
        while (a_fd_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_timeout_784", 32'(a_fd_cnt >= target), 32'd1);
    endtask

    task automatic wait_b(input int target, input int limit);
        int n = 0;
        while (b_fd_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_timeout_10", 32'(b_fd_cnt >= target), 32'd1);
    endtask

    // Expected pixel stream: bit order chosen by the build, truncated at 784 pixels.
    task automatic load_frame_a(input logic [7:0] pay[$]);
        exp_q.delete();
        a_tx.push_back(8'hA5);
        foreach (pay[i]) begin
            a_tx.push_back(pay[i]);
            for (int j = 0; j < 8; j++)
                if (exp_q.size() < 784) exp_q.push_back(LSB ? pay[i][j] : pay[i][7-j]);
        end
    endtask

    task automatic cmp_stream(input string nm);
        int m = 0;
        chk({nm, "_len"}, a_rx.size(), exp_q.size());
        for (int i = 0; i < a_rx.size() && i < exp_q.size(); i++)
            if (a_rx[i] !== exp_q[i]) m++;
        chk({nm, "_bits"}, m, 0);
    endtask

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] trail;
        logic [9:0] exp_msb;
        logic [9:0] exp_lsb;
        logic [7:0] drops;
    } vec_t;

    initial begin
        vec_t       tbl[5];
        logic [7:0] pay[$];
        logic [9:0] got10;
        logic [7:0] got8;
        int         cnt;

        tbl[0] = '{8'hB4, 8'hC0, 8'hFF, 10'b1011010011, 10'b0010110100, 8'd1};
        tbl[1] = '{8'hA5, 8'h03, 8'h00, 10'b1010010100, 10'b1010010111, 8'd2};
        tbl[2] = '{8'hB4, 8'h03, 8'h12, 10'b1011010000, 10'b0010110111, 8'd3};
        tbl[3] = '{8'h00, 8'hFF, 8'h77, 10'b0000000011, 10'b0000000011, 8'd4};
        tbl[4] = '{8'hFF, 8'h40, 8'h5A, 10'b1111111101, 10'b1111111100, 8'd5};

        rst = 1'b1;
        tick(3);
        chk("rst_valid", a_pbv, 1'b0);
        chk("rst_bit", a_pb, 1'b0);
        chk("rst_done", a_fd, 1'b0);
        chk("rst_fcount", a_fc, 16'd0);
        chk("rst_dcount", a_dc, 8'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_byte_ready", a_br, 1'b0);
        rst = 1'b0;
        tick(2);
        chk("idle_byte_ready", a_br, 1'b1);

        // Ten-pixel frames: partial last byte, trailing byte dropped in HUNT.
        for (int v = 0; v < 5; v++) begin
            b_rx.delete();
            b_tx.push_back(8'hA5);
            b_tx.push_back(tbl[v].d0);
            b_tx.push_back(tbl[v].d1);
            b_tx.push_back(tbl[v].trail);
            wait_b(v + 1, 200);
            tick(5);
            got10 = '0;
            foreach (b_rx[i]) got10 = {got10[8:0], b_rx[i]};
            chk($sformatf("p10_len_%0d", v), b_rx.size(), 10);
            chk($sformatf("p10_bits_%0d", v), got10, LSB ? tbl[v].exp_lsb : tbl[v].exp_msb);
            chk($sformatf("p10_drop_%0d", v), b_dc, tbl[v].drops);
        end
        chk("p10_fcount", b_fc, 16'd5);
        chk("p10_done_pulses", b_fd_cnt, 5);

        // Full frame of ones, no backpressure.
        a_rx.delete(); a_fill = 0; a_emit = 0; a_viol = 0;
        pay.delete();
        for (int i = 0; i < 98; i++) pay.push_back(8'hFF);
        load_frame_a(pay);
        wait_a(1, 3000);
        tick(5);
        cmp_stream("full");
        cnt = 0;
        foreach (a_rx[i]) if (a_rx[i] === 1'b1) cnt++;
        chk("full_ones", cnt, 784);
        chk("full_fcount", a_fc, 16'd1);
        chk("full_done_pulses", a_fd_cnt, 1);
        chk("full_done_after_last", a_fd_at, 784);
        chk("full_fill_cycles", a_fill, 98);
        chk("full_emit_cycles", a_emit, 784);
        chk("full_ready_in_emit", a_viol, 0);

        // Sync hunt with junk bytes and an embedded sync value in the payload.
        a_rx.delete();
        a_tx.push_back(8'h00); a_tx.push_back(8'h12); a_tx.push_back(8'hFF);
        pay.delete();
        for (int i = 0; i < 98; i++) pay.push_back((i == 10) ? 8'hA5 : 8'h55);
        load_frame_a(pay);
        wait_a(2, 3000);
        tick(5);
        cmp_stream("hunt");
        chk("hunt_drops", a_dc, 8'd3);
        chk("hunt_fcount", a_fc, 16'd2);
        got8 = '0;
        for (int i = 0; i < 8; i++) got8 = {got8[6:0], a_rx[i]};
        chk("hunt_first_byte", got8, LSB ? 8'hAA : 8'h55);
        got8 = '0;
        for (int i = 80; i < 88; i++) got8 = {got8[6:0], a_rx[i]};
        chk("hunt_sync_as_data", got8, 8'hA5);

        // Random backpressure over a random-payload frame.
        a_rx.delete(); a_viol = 0;
        pay.delete();
        for (int i = 0; i < 98; i++) pay.push_back(8'($urandom));
        a_rand = 1'b1;
        load_frame_a(pay);
        wait_a(3, 8000);
        tick(5);
        a_rand = 1'b0;
        cmp_stream("bp");
        chk("bp_stable_stall", a_viol, 0);
        chk("bp_done_after_last", a_fd_at, 784);
        chk("bp_done_pulses", a_fd_cnt, 3);
        chk("bp_fcount", a_fc, 16'd3);

        // Asynchronous reset part-way through a frame, then a clean frame.
        a_rx.delete();
        pay.delete();
        for (int i = 0; i < 98; i++) pay.push_back(8'hFF);
        load_frame_a(pay);
        cnt = 0;
        while (a_rx.size() < 300 && cnt < 2000) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("mid_reached_300", 32'(a_rx.size() >= 300), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_pbv, 1'b0);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_fcount", a_fc, 16'd0);
        chk("mid_rst_dcount", a_dc, 8'd0);
        chk("mid_rst_byte_ready", a_br, 1'b0);
        a_tx.delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        a_rx.delete(); a_fd_cnt = 0;
        load_frame_a(pay);
        wait_a(1, 3000);
        tick(5);
        cmp_stream("after_rst");
        chk("after_rst_fcount", a_fc, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
